// File: rtl/rv32e_mem_pkg.sv
// Shared constants and types for the RV32E load/store access unit.
package rv32e_mem_pkg;

  // RV32 load/store funct3 encodings (store encodings reuse B/H/W)
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Memory-mapped I/O words at the bottom of the data RAM
  localparam logic [31:0] MMIO_IN_ADDR  = 32'd0;
  localparam logic [31:0] MMIO_OUT_ADDR = 32'd4;

  localparam int DEFAULT_MEM_BYTES = 100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // True when funct3 names a load the unit implements
  function automatic logic load_f3_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // True when funct3 names a store the unit implements
  function automatic logic store_f3_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational data steering: load extraction/extension and the
// byte/half merge used by read-modify-write stores. The addressed byte
// always sits in rdata[31:24].
module lsu_data_align
  import rv32e_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  // Pick the addressed byte/half and sign- or zero-extend it
  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{rdata[31]}}, rdata[31:24]};
      F3_BU:   load_data = {24'd0, rdata[31:24]};
      F3_H:    load_data = {{16{rdata[31]}}, rdata[31:16]};
      F3_HU:   load_data = {16'd0, rdata[31:16]};
      default: load_data = rdata;
    endcase
  end

  // Overlay the store byte/half onto the word read back, keeping the rest
  always_comb begin
    merge_data = wdata;
    case (funct3)
      F3_B:    merge_data = {wdata[7:0], rdata[23:0]};
      F3_H:    merge_data = {wdata[15:0], rdata[15:0]};
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a single-issue core and a byte-addressed data
// RAM with combinational read. Sub-word stores are done as read-modify-write.
module mem_access_unit
  import rv32e_mem_pkg::*;
#(
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
  parameter int RO_BYTES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  // Highest legal word address; the whole 4-byte window must be in RAM
  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);
  localparam logic [31:0] RO_LIMIT = 32'(RO_BYTES);

  state_e      state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic        f3_bad;
  logic        req_fault;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  lsu_data_align u_align (
    .funct3     (funct3_q),
    .rdata      (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Classify an incoming request as one that must never reach the RAM
  always_comb begin
    if (req_store) f3_bad = !store_f3_ok(req_funct3);
    else           f3_bad = !load_f3_ok(req_funct3);
    req_fault = (req_addr > MAX_ADDR) || f3_bad ||
                (req_store && (req_addr < RO_LIMIT));
  end

  // Sequencing: accept in IDLE, then read and/or write, then one RESP cycle
  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = 32'd0;
          fault_d  = req_fault;
          if (req_fault)                 state_d = ST_RESP;
          else if (!req_store)           state_d = ST_RD;
          else if (req_funct3 == F3_W)   state_d = ST_WR;
          else                           state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (store_q) begin
          wdata_d = merge_data;
          state_d = ST_WR;
        end else begin
          rdata_d = load_data;
          state_d = ST_RESP;
        end
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  // Outputs decode from state so nothing leaks outside the owning phase
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_fault = resp_valid & fault_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign mem_write  = (state_q == ST_WR);
  assign mem_addr   = ((state_q == ST_RD) || (state_q == ST_WR)) ? addr_q : 32'd0;
  assign mem_wdata  = mem_write ? wdata_q : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a byte-array RAM, a transaction-level
// reference model, and a per-cycle compare process.
module tb_mem_access_unit;

  localparam int MB = 100;
  localparam int RO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(MB), .RO_BYTES(RO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  logic [7:0] dut_mem [MB];
  logic [7:0] ref_mem [MB];
  bit         do_load = 1'b1;

  // RAM the DUT talks to
  always_comb begin
    mem_rdata = 32'd0;
    if (mem_addr <= 32'(MB - 4))
      mem_rdata = {dut_mem[mem_addr[6:0]], dut_mem[7'(mem_addr[6:0] + 7'd1)],
                   dut_mem[7'(mem_addr[6:0] + 7'd2)], dut_mem[7'(mem_addr[6:0] + 7'd3)]};
  end

  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < MB; i++) dut_mem[i] <= ref_mem[i];
    end else if (mem_write && mem_addr <= 32'(MB - 4)) begin
      dut_mem[mem_addr[6:0]]                 <= mem_wdata[31:24];
      dut_mem[7'(mem_addr[6:0] + 7'd1)]      <= mem_wdata[23:16];
      dut_mem[7'(mem_addr[6:0] + 7'd2)]      <= mem_wdata[15:8];
      dut_mem[7'(mem_addr[6:0] + 7'd3)]      <= mem_wdata[7:0];
    end
  end

  int n_cmp = 0;
  int n_fail = 0;
  int n_txn = 0;
  bit chk_en = 1'b0;

  logic        exp_ready = 1'b1, exp_valid = 1'b0, exp_fault = 1'b0, exp_mw = 1'b0;
  logic [31:0] exp_rdata = 32'd0, exp_addr = 32'd0, exp_wdata = 32'd0;
  logic [31:0] last_rdata = 32'd0, last_wdata = 32'd0;
  logic        last_fault = 1'b0;
  int          mw_count = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model's expectations
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready",  32'(req_ready),  32'(exp_ready));
      chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
      chk("resp_fault", 32'(resp_fault), 32'(exp_fault));
      chk("resp_rdata", resp_rdata, exp_rdata);
      chk("mem_write",  32'(mem_write),  32'(exp_mw));
      chk("mem_addr",   mem_addr, exp_addr);
      if (exp_mw) chk("mem_wdata", mem_wdata, exp_wdata);
      if (resp_valid) begin
        last_rdata <= resp_rdata;
        last_fault <= resp_fault;
      end
      if (mem_write) begin
        last_wdata <= mem_wdata;
        mw_count   <= mw_count + 1;
      end
    end
  end

  task automatic set_exp(input logic rdy, input logic v, input logic f, input logic mw,
                         input logic [31:0] rd, input logic [31:0] ad, input logic [31:0] wd);
    exp_ready = rdy; exp_valid = v; exp_fault = f; exp_mw = mw;
    exp_rdata = rd;  exp_addr = ad; exp_wdata = wd;
  endtask

  // Reference model: outcome of one request from the RAM image and the rules
  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] w, output bit flt, output int lat,
                       output logic [31:0] rd, output logic [31:0] wd);
    int ai, b0, b1, b2, b3, h;
    flt = 1'b0;
    rd  = 32'd0;
    wd  = 32'd0;
    lat = 1;
    if (a > 32'(MB - 4)) flt = 1'b1;
    if (st && f3 > 3'd2) flt = 1'b1;
    if (!st && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) flt = 1'b1;
    if (st && a < 32'(RO)) flt = 1'b1;
    if (!flt) begin
      ai = int'(a);
      b0 = int'(ref_mem[ai]);     b1 = int'(ref_mem[ai + 1]);
      b2 = int'(ref_mem[ai + 2]); b3 = int'(ref_mem[ai + 3]);
      h  = b0 * 256 + b1;
      if (!st) begin
        lat = 2;
        case (f3)
          3'd0: rd = 32'(b0 >= 128 ? b0 - 256 : b0);
          3'd4: rd = 32'(b0);
          3'd1: rd = 32'(h >= 32768 ? h - 65536 : h);
          3'd5: rd = 32'(h);
          default: rd = 32'(((b0 * 256 + b1) * 256 + b2) * 256 + b3);
        endcase
      end else begin
        case (f3)
          3'd0: begin ref_mem[ai] = w[7:0]; lat = 3; end
          3'd1: begin ref_mem[ai] = w[15:8]; ref_mem[ai + 1] = w[7:0]; lat = 3; end
          default: begin
            ref_mem[ai] = w[31:24]; ref_mem[ai + 1] = w[23:16];
            ref_mem[ai + 2] = w[15:8]; ref_mem[ai + 3] = w[7:0];
            lat = 2;
          end
        endcase
        wd = {ref_mem[ai], ref_mem[ai + 1], ref_mem[ai + 2], ref_mem[ai + 3]};
      end
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    repeat (n) begin
      req_addr  = $urandom;
      req_wdata = $urandom;
      @(posedge clk); #1;
    end
  endtask

  // Present one request and lay out the expected cycle-by-cycle behaviour
  task automatic run_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] w);
    bit flt;
    int lat;
    logic [31:0] rd, wd;
    bit wr_op, last;
    model(st, f3, a, w, flt, lat, rd, wd);
    wr_op = st && !flt;
    n_txn++;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = w;
    @(posedge clk); #1;
    for (int t = 1; t <= lat; t++) begin
      last = (t == lat);
      set_exp(1'b0, last, last && flt, wr_op && (t == lat - 1),
              last ? rd : 32'd0, (!flt && !last) ? a : 32'd0, wd);
      // Inputs while busy are noise the DUT must ignore
      req_valid  = 1'($urandom_range(0, 1));
      req_store  = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr   = 32'($urandom_range(4, MB - 4));
      req_wdata  = $urandom;
      @(posedge clk); #1;
    end
    idle(0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    for (int i = 0; i < MB; i++) ref_mem[i] = 8'($urandom);
    ref_mem[0] = 8'h11; ref_mem[1] = 8'h22; ref_mem[2] = 8'h33; ref_mem[3] = 8'h44;
    ref_mem[8] = 8'h80; ref_mem[9] = 8'h12; ref_mem[10] = 8'h34; ref_mem[11] = 8'h56;
    ref_mem[12] = 8'h00; ref_mem[13] = 8'h00;
    ref_mem[20] = 8'hCA; ref_mem[21] = 8'hFE; ref_mem[22] = 8'hBA; ref_mem[23] = 8'hBE;

    // Reset, with the RAM image loaded while reset is held
    repeat (2) @(posedge clk);
    #1;
    do_load = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);

    // Loads on the preloaded pattern
    run_req(1'b0, 3'd0, 32'd8, 32'd0);  chk("LB@8", last_rdata, 32'hFFFFFF80);
    run_req(1'b0, 3'd4, 32'd8, 32'd0);  chk("LBU@8", last_rdata, 32'h00000080);
    run_req(1'b0, 3'd1, 32'd9, 32'd0);  chk("LH@9", last_rdata, 32'h00001234);
    run_req(1'b0, 3'd2, 32'd8, 32'd0);  chk("LW@8", last_rdata, 32'h80123456);
    idle(2);

    // Byte store by read-modify-write
    run_req(1'b1, 3'd0, 32'd10, 32'h000000AB);
    chk("SB@10 wdata", last_wdata, 32'hAB560000);
    chk("SB@10 fault", 32'(last_fault), 32'd0);

    // Word stores at and past the top boundary
    run_req(1'b1, 3'd2, 32'd96, 32'hDEADBEEF);
    chk("SW@96 fault", 32'(last_fault), 32'd0);
    run_req(1'b0, 3'd2, 32'd96, 32'd0);
    chk("LW@96", last_rdata, 32'hDEADBEEF);
    m = mw_count;
    run_req(1'b1, 3'd2, 32'd97, 32'h12345678);
    chk("SW@97 fault", 32'(last_fault), 32'd1);
    chk("SW@97 no write", 32'(mw_count), 32'(m));

    // Read-only region and illegal funct3
    run_req(1'b1, 3'd1, 32'd2, 32'h0000BEEF);
    chk("SH@2 fault", 32'(last_fault), 32'd1);
    run_req(1'b0, 3'd2, 32'd0, 32'd0);
    chk("LW@0", last_rdata, 32'h11223344);
    run_req(1'b0, 3'd3, 32'd8, 32'd0);
    chk("LD3 fault", 32'(last_fault), 32'd1);
    chk("LD3 rdata", last_rdata, 32'd0);
    run_req(1'b0, 3'd2, 32'hFFFFFFFC, 32'd0);
    chk("LW wrap fault", 32'(last_fault), 32'd1);

    // Reset during the RD phase of a byte store
    m = mw_count;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0;
    req_addr = 32'd20; req_wdata = 32'h00000077;
    @(posedge clk); #1;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd20, 32'd0);
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);
    chk("abort no write", 32'(mw_count), 32'(m));
    run_req(1'b0, 3'd2, 32'd20, 32'd0);
    chk("LW@20 after abort", last_rdata, 32'hCAFEBABE);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [2:0]  f3;
      bit          st;
      int          sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       a = $urandom;
        1:       a = 32'(MB - 4 + $urandom_range(0, 4));
        2:       a = 32'($urandom_range(0, 3));
        default: a = 32'($urandom_range(0, MB - 4));
      endcase
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (st) f3 = 3'($urandom_range(0, 2));
        else begin
          case ($urandom_range(0, 4))
            0: f3 = 3'd0;
            1: f3 = 3'd1;
            2: f3 = 3'd2;
            3: f3 = 3'd4;
            default: f3 = 3'd5;
          endcase
        end
      end
      run_req(st, f3, a, $urandom);
      idle($urandom_range(0, 2));
    end

    // RAM image must match the model byte for byte
    for (int i = 0; i < MB; i++) chk("ram byte", 32'(dut_mem[i]), 32'(ref_mem[i]));

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
